// File: rtl/cpu_bus_pkg.sv
// Shared types and default widths for the unified-memory CPU bus.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Which port owns the SRAM access currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/rsp_hold_buf.sv
// One-entry response skid buffer. A response passes straight through when the
// consumer is ready. Otherwise it is held until out_ready is seen.
module rsp_hold_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              full
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Capture an unaccepted response; release the held one on out_ready.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (out_ready) begin
                full_d = 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    // Held response wins; otherwise bypass. Data reads 0 when nothing is valid.
    always_comb begin
        out_valid = full_q | in_valid;
        if (full_q) begin
            out_data = data_q;
        end else if (in_valid) begin
            out_data = in_data;
        end else begin
            out_data = '0;
        end
        full = full_q;
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency SRAM between the inst and data ports.
// Data normally wins; inst is forced through after STARVE_MAX denied cycles.
module sram_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              i_rready,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_rready,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned     CntW      = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveTop = CntW'(STARVE_MAX);

    owner_e          owner_q, owner_d;
    logic            d_wr_q, d_wr_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic i_full, d_full;
    logic i_elig, d_elig;
    logic win_i, win_d;
    logic i_rsp_valid, d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;

    // Eligibility and arbitration. A response landing now that the port will not
    // take is about to occupy its buffer, so it blocks a new grant as well.
    always_comb begin
        i_elig = i_req && !i_full && !((owner_q == OWN_I) && !i_rready);
        d_elig = d_req && !d_full && !((owner_q == OWN_D) && !d_rready);
        win_i  = i_elig && (!d_elig || (starve_q == StarveTop));
        win_d  = d_elig && !win_i;
    end

    // Grant and SRAM drive; everything is forced low while reset is high.
    always_comb begin
        i_gnt      = win_i & ~reset;
        d_gnt      = win_d & ~reset;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!reset) begin
            if (win_d) begin
                sram_en    = 1'b1;
                sram_we    = d_we;
                sram_addr  = d_addr;
                sram_wdata = d_wdata;
            end else if (win_i) begin
                sram_en   = 1'b1;
                sram_addr = i_addr;
            end
        end
    end

    // Next owner, write flag for the in-flight data access, and starvation count.
    always_comb begin
        owner_d  = OWN_NONE;
        d_wr_d   = 1'b0;
        starve_d = starve_q;
        if (win_i) begin
            owner_d = OWN_I;
        end else if (win_d) begin
            owner_d = OWN_D;
            d_wr_d  = (d_we != 4'b0000);
        end
        if (!i_req || win_i) begin
            starve_d = '0;
        end else if (i_elig && (starve_q != StarveTop)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Route the SRAM response to its owner; write acks carry zero data.
    always_comb begin
        i_rsp_valid = (owner_q == OWN_I);
        d_rsp_valid = (owner_q == OWN_D);
        d_rsp_data  = d_wr_q ? '0 : sram_rdata;
    end

    // Owner FSM, write flag and starvation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            d_wr_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            d_wr_q   <= d_wr_d;
            starve_q <= starve_d;
        end
    end

    rsp_hold_buf #(
        .DATA_W (DATA_W)
    ) u_i_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (i_rsp_valid),
        .in_data   (sram_rdata),
        .out_ready (i_rready),
        .out_valid (i_rvalid),
        .out_data  (i_rdata),
        .full      (i_full)
    );

    rsp_hold_buf #(
        .DATA_W (DATA_W)
    ) u_d_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d_rsp_valid),
        .in_data   (d_rsp_data),
        .out_ready (d_rready),
        .out_valid (d_rvalid),
        .out_data  (d_rdata),
        .full      (d_full)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, i_rready = 1'b1;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0, d_rready = 1'b1;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0, d_wdata = '0, sram_rdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, sram_en;
    logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_we;

    int total = 0;
    int bad = 0;

    sram_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (MAXS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .i_rready   (i_rready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_rready   (d_rready),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what each port is owed and who accessed the SRAM last cycle.
    int          m_owner = 0;      // 0 none, 1 inst, 2 data
    bit          m_wr = 0;
    bit          m_ih_v = 0, m_dh_v = 0;
    logic [31:0] m_ih_d = '0, m_dh_d = '0;
    int          m_starve = 0;

    always @(negedge clk) begin
        bit          e_iv, e_dv, i_ok, d_ok;
        int          win;
        logic [31:0] e_id, e_dd, e_addr, e_wd, land_d;
        logic [3:0]  e_we;
        if (reset) begin
            chk("rst_ctl", {27'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, sram_en}, 32'd0);
            chk("rst_dat", i_rdata | d_rdata | sram_addr | sram_wdata | {28'd0, sram_we}, 32'd0);
            m_owner = 0; m_wr = 0; m_ih_v = 0; m_dh_v = 0; m_starve = 0;
        end else begin
            land_d = m_wr ? 32'd0 : sram_rdata;
            e_iv = m_ih_v || (m_owner == 1);
            e_id = m_ih_v ? m_ih_d : sram_rdata;
            e_dv = m_dh_v || (m_owner == 2);
            e_dd = m_dh_v ? m_dh_d : land_d;
            // A port may not have two responses outstanding.
            i_ok = i_req && !m_ih_v && !(m_owner == 1 && !i_rready);
            d_ok = d_req && !m_dh_v && !(m_owner == 2 && !d_rready);
            if (i_ok && d_ok) win = (m_starve == MAXS) ? 1 : 2;
            else if (i_ok) win = 1;
            else if (d_ok) win = 2;
            else win = 0;
            e_addr = (win == 1) ? i_addr : (win == 2) ? d_addr : 32'd0;
            e_we   = (win == 2) ? d_we : 4'd0;
            e_wd   = (win == 2) ? d_wdata : 32'd0;
            chk("m_i_gnt", {31'd0, i_gnt}, {31'd0, win == 1});
            chk("m_d_gnt", {31'd0, d_gnt}, {31'd0, win == 2});
            chk("m_sram_en", {31'd0, sram_en}, {31'd0, win != 0});
            chk("m_sram_we", {28'd0, sram_we}, {28'd0, e_we});
            if (win != 0) chk("m_sram_addr", sram_addr, e_addr);
            if (win == 2) chk("m_sram_wdata", sram_wdata, e_wd);
            chk("m_i_rvalid", {31'd0, i_rvalid}, {31'd0, e_iv});
            chk("m_d_rvalid", {31'd0, d_rvalid}, {31'd0, e_dv});
            if (e_iv) chk("m_i_rdata", i_rdata, e_id);
            if (e_dv) chk("m_d_rdata", d_rdata, e_dd);
            // Advance model.
            if (m_ih_v) begin
                if (i_rready) m_ih_v = 0;
            end else if (m_owner == 1 && !i_rready) begin
                m_ih_v = 1; m_ih_d = sram_rdata;
            end
            if (m_dh_v) begin
                if (d_rready) m_dh_v = 0;
            end else if (m_owner == 2 && !d_rready) begin
                m_dh_v = 1; m_dh_d = land_d;
            end
            if (!i_req || win == 1) m_starve = 0;
            else if (i_ok && m_starve < MAXS) m_starve++;
            m_owner = win;
            m_wr = (win == 2) && (d_we != 0);
        end
    end

    // Start a cycle: after the edge, return inputs to an idle default.
    task automatic cyc();
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'h0; i_rready = 1'b1;
        d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; d_rready = 1'b1;
        sram_rdata = 32'h0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        cyc();
        cyc();

        // Data read passes straight through.
        cyc(); d_req = 1; d_addr = 32'h1c00_0010;
        @(negedge clk);
        chk("t1_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
        chk("t1_addr", sram_addr, 32'h1c00_0010);
        cyc(); sram_rdata = 32'hdead_beef;
        @(negedge clk);
        chk("t1_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd1);
        chk("t1_rdata", d_rdata, 32'hdead_beef);

        // Data write acked with zero data.
        cyc(); d_req = 1; d_we = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("t4_we", {28'd0, sram_we}, 32'h3);
        chk("t4_wdata", sram_wdata, 32'h1234_5678);
        cyc(); sram_rdata = 32'ha5a5_a5a5;
        @(negedge clk);
        chk("t4_ack", {31'd0, d_rvalid}, 32'd1);
        chk("t4_rdata", d_rdata, 32'd0);

        // Both requesting: D,D,D,D,I repeating.
        for (int k = 0; k < 10; k++) begin
            cyc(); i_req = 1; d_req = 1; i_addr = 32'h100 + k; d_addr = 32'h200 + k;
            sram_rdata = 32'h5000 + k;
            @(negedge clk);
            chk("t2_i_gnt", {31'd0, i_gnt}, {31'd0, (k % 5) == 4});
            chk("t2_d_gnt", {31'd0, d_gnt}, {31'd0, (k % 5) != 4});
        end
        cyc();
        cyc();

        // Inst response held while fetch stalls.
        cyc(); i_req = 1; i_rready = 0; i_addr = 32'h80;
        @(negedge clk);
        chk("t3_gnt0", {31'd0, i_gnt}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); i_req = 1; i_rready = 0; i_addr = 32'h84;
            sram_rdata = (k == 0) ? 32'h1122_3344 : $urandom;
            @(negedge clk);
            chk("t3_hold_v", {31'd0, i_rvalid}, 32'd1);
            chk("t3_hold_d", i_rdata, 32'h1122_3344);
            chk("t3_no_gnt", {31'd0, i_gnt}, 32'd0);
        end
        cyc(); i_req = 1; i_addr = 32'h84;
        @(negedge clk);
        chk("t3_rel_d", i_rdata, 32'h1122_3344);
        chk("t3_rel_gnt", {31'd0, i_gnt}, 32'd0);
        cyc(); i_req = 1; i_addr = 32'h84;
        @(negedge clk);
        chk("t3_regnt", {31'd0, i_gnt}, 32'd1);
        cyc(); sram_rdata = 32'h55;
        @(negedge clk);
        chk("t3_last", i_rdata, 32'h55);

        // Reset the cycle after a grant drops the in-flight access.
        cyc(); d_req = 1; d_addr = 32'h10;
        @(negedge clk);
        chk("t5_gnt", {31'd0, d_gnt}, 32'd1);
        cyc(); reset = 1; d_req = 1; i_req = 1; sram_rdata = 32'h77;
        @(negedge clk);
        chk("t5_rst", {27'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, sram_en}, 32'd0);
        cyc(); sram_rdata = 32'h77;
        @(negedge clk);
        chk("t5_after", {30'd0, i_rvalid, d_rvalid}, 32'd0);

        // Alternating ports: each response reaches its own requester.
        cyc(); i_req = 1; i_addr = 32'h1000;
        @(negedge clk);
        chk("t6_g0", {30'd0, i_gnt, d_gnt}, 32'd2);
        cyc(); d_req = 1; d_addr = 32'h2000; sram_rdata = 32'haaaa_0001;
        @(negedge clk);
        chk("t6_g1", {30'd0, i_gnt, d_gnt}, 32'd1);
        chk("t6_r1", {i_rdata[30:0], i_rvalid & ~d_rvalid}, {32'haaaa_0001 << 1} | 32'd1);
        cyc(); i_req = 1; i_addr = 32'h1004; sram_rdata = 32'hbbbb_0002;
        @(negedge clk);
        chk("t6_r2", d_rdata, 32'hbbbb_0002);
        chk("t6_r2v", {30'd0, i_rvalid, d_rvalid}, 32'd1);
        cyc(); sram_rdata = 32'hcccc_0003;
        @(negedge clk);
        chk("t6_r3", i_rdata, 32'hcccc_0003);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc();
            reset      = ($urandom_range(0, 299) == 0);
            i_req      = ($urandom_range(0, 3) != 0);
            d_req      = ($urandom_range(0, 2) != 0);
            i_addr     = $urandom;
            d_addr     = $urandom;
            d_wdata    = $urandom;
            d_we       = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            i_rready   = ($urandom_range(0, 3) != 0);
            d_rready   = ($urandom_range(0, 3) != 0);
            sram_rdata = $urandom;
        end
        cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
